// File: rtl/stopwatch_digit_source.sv
// stopwatch_digit_source: debounces two raw push-buttons, runs a 0.1 s BCD
// stopwatch (000.0 - 999.9 s) and presents four registered segment patterns
// for a multiplexed 4-digit 7-segment driver.
// Segment bits (active-high): 7 DP, 6 middle, 5 right-low, 4 bottom,
// 3 left-low, 2 left-high, 1 top, 0 right-high.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero digits
// (digit3, then digit2) while not in overflow.

module stopwatch_debounce #(
    parameter int DEBOUNCE_CYCLES = 240_000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic press_pulse
);
    localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]   CNT_ZERO = CW'(0);

    logic          sync1_r;
    logic          sync2_r;
    logic          level_r;
    logic [CW-1:0] cnt_r;
    logic          settle_s;

    // The level may flip once the synced value has differed for the whole window
    always_comb begin
        if ((sync2_r != level_r) && (cnt_r == CNT_LAST)) begin
            settle_s = 1'b1;
        end else begin
            settle_s = 1'b0;
        end
    end

    // A press is the 0->1 flip of the debounced level; releases make no pulse
    assign press_pulse = settle_s & sync2_r;

    // Two-flop synchronizer, stability counter and debounced level
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            level_r <= 1'b0;
            cnt_r   <= CNT_ZERO;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
            if (sync2_r == level_r) begin
                cnt_r <= CNT_ZERO;
            end else if (settle_s) begin
                level_r <= sync2_r;
                cnt_r   <= CNT_ZERO;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end
endmodule

module stopwatch_digit_source #(
    parameter int TICK_DIV        = 2_400_000,
    parameter int DEBOUNCE_CYCLES = 240_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       button_start_stop,
    input  logic       button_clear,
    output logic [7:0] digit0,
    output logic [7:0] digit1,
    output logic [7:0] digit2,
    output logic [7:0] digit3,
    output logic       running,
    output logic       overflow
);
    localparam int            PW       = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRE_ONE  = PW'(1);
    localparam logic [PW-1:0] PRE_ZERO = PW'(0);

    localparam logic [7:0] SEG_DP    = 8'b1000_0000;
    localparam logic [7:0] SEG_DASH  = 8'b0100_0000;
    localparam logic [7:0] SEG_BLANK = 8'b0000_0000;
    localparam logic [7:0] SEG_ZERO  = 8'b0011_1111;

    // BCD digit to segment pattern; non-decimal codes fall back to a dash
    function automatic logic [7:0] seg_code(input logic [3:0] bcd);
        case (bcd)
            4'd0:    seg_code = 8'b0011_1111;
            4'd1:    seg_code = 8'b0010_0001;
            4'd2:    seg_code = 8'b0101_1011;
            4'd3:    seg_code = 8'b0111_0011;
            4'd4:    seg_code = 8'b0110_0101;
            4'd5:    seg_code = 8'b0111_0110;
            4'd6:    seg_code = 8'b0111_1110;
            4'd7:    seg_code = 8'b0010_0011;
            4'd8:    seg_code = 8'b0111_1111;
            4'd9:    seg_code = 8'b0111_0111;
            default: seg_code = 8'b0100_0000;
        endcase
    endfunction

    logic            ss_press_s;
    logic            clr_press_s;
    logic [3:0][3:0] bcd_r;
    logic [3:0][3:0] bcd_inc_s;
    logic [PW-1:0]   pre_r;
    logic            running_r;
    logic            overflow_r;
    logic            tick_s;
    logic            bcd_max_s;

    stopwatch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start_stop (
        .clock       (clock),
        .reset       (reset),
        .raw         (button_start_stop),
        .press_pulse (ss_press_s)
    );

    stopwatch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
        .clock       (clock),
        .reset       (reset),
        .raw         (button_clear),
        .press_pulse (clr_press_s)
    );

    assign running  = running_r;
    assign overflow = overflow_r;

    // Decimal increment rippling the carry from tenths up to hundreds
    always_comb begin
        logic carry_v;
        bcd_inc_s = bcd_r;
        carry_v   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry_v) begin
                if (bcd_r[i] == 4'd9) begin
                    bcd_inc_s[i] = 4'd0;
                    carry_v      = 1'b1;
                end else begin
                    bcd_inc_s[i] = bcd_r[i] + 4'd1;
                    carry_v      = 1'b0;
                end
            end else begin
                bcd_inc_s[i] = bcd_r[i];
                carry_v      = 1'b0;
            end
        end
    end

    // Tick on the last prescaler count of a running period; detect 999.9
    always_comb begin
        if (running_r && (pre_r == PRE_LAST)) begin
            tick_s = 1'b1;
        end else begin
            tick_s = 1'b0;
        end
        if (bcd_r == 16'h9999) begin
            bcd_max_s = 1'b1;
        end else begin
            bcd_max_s = 1'b0;
        end
    end

    // Stopwatch control: clear wins, then ticks, start/stop toggling and saturation
    always_ff @(posedge clock) begin
        if (reset) begin
            bcd_r      <= 16'h0000;
            pre_r      <= PRE_ZERO;
            running_r  <= 1'b0;
            overflow_r <= 1'b0;
        end else if (clr_press_s) begin
            bcd_r      <= 16'h0000;
            pre_r      <= PRE_ZERO;
            running_r  <= 1'b0;
            overflow_r <= 1'b0;
        end else if (tick_s) begin
            pre_r <= PRE_ZERO;
            if (bcd_max_s) begin
                overflow_r <= 1'b1;
                running_r  <= 1'b0;
            end else begin
                bcd_r <= bcd_inc_s;
                if (ss_press_s) begin
                    running_r <= ~running_r;
                end else begin
                    running_r <= running_r;
                end
            end
        end else begin
            if (running_r) begin
                pre_r <= pre_r + PRE_ONE;
            end else begin
                pre_r <= pre_r;
            end
            if (ss_press_s && !overflow_r) begin
                running_r <= ~running_r;
            end else begin
                running_r <= running_r;
            end
        end
    end

    // Segment patterns registered one cycle behind the BCD/overflow state
    always_ff @(posedge clock) begin
        if (reset) begin
            digit0 <= SEG_ZERO;
            digit1 <= SEG_DP | SEG_ZERO;
            digit2 <= SEG_ZERO;
            digit3 <= SEG_ZERO;
        end else if (overflow_r) begin
            digit0 <= SEG_DASH;
            digit1 <= SEG_DP | SEG_DASH;
            digit2 <= SEG_DASH;
            digit3 <= SEG_DASH;
        end else begin
            digit0 <= seg_code(bcd_r[0]);
            digit1 <= SEG_DP | seg_code(bcd_r[1]);
`ifdef LEADING_ZERO_BLANK_EN
            if (bcd_r[3] == 4'd0) begin
                digit3 <= SEG_BLANK;
            end else begin
                digit3 <= seg_code(bcd_r[3]);
            end
            if ((bcd_r[3] == 4'd0) && (bcd_r[2] == 4'd0)) begin
                digit2 <= SEG_BLANK;
            end else begin
                digit2 <= seg_code(bcd_r[2]);
            end
`else
            digit2 <= seg_code(bcd_r[2]);
            digit3 <= seg_code(bcd_r[3]);
`endif
        end
    end
endmodule

// File: tb/tb_stopwatch_digit_source.sv
// Self-checking bench for stopwatch_digit_source: random button activity
// (bounces, short glitches, simultaneous presses, mid-run resets) compared
// every cycle against a time-in-tenths reference model.

module tb_stopwatch_digit_source;
    localparam int TICK_DIV = 4;
    localparam int DEB      = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       button_start_stop = 1'b0;
    logic       button_clear = 1'b0;
    logic [7:0] digit0, digit1, digit2, digit3;
    logic       running, overflow;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    stopwatch_digit_source #(.TICK_DIV(TICK_DIV), .DEBOUNCE_CYCLES(DEB)) dut (
        .clock             (clock),
        .reset             (reset),
        .button_start_stop (button_start_stop),
        .button_clear      (button_clear),
        .digit0            (digit0),
        .digit1            (digit1),
        .digit2            (digit2),
        .digit3            (digit3),
        .running           (running),
        .overflow          (overflow)
    );

    logic [7:0] seg_tab [10] = '{8'h3F, 8'h21, 8'h5B, 8'h73, 8'h65,
                                 8'h76, 8'h7E, 8'h23, 8'h7F, 8'h77};

    // reference model state
    bit           m_pipe  [2][2];   // raw samples from 1 and 2 edges ago
    logic [DEB-1:0] m_hist [2];     // most recent synced samples
    bit           m_level [2];
    int           m_tenths = 0;     // elapsed time in 0.1 s units
    int           m_phase  = 0;     // running cycles into current tick period
    bit           m_run    = 1'b0;
    bit           m_ovf    = 1'b0;
    logic [7:0]   e_d0, e_d1, e_d2, e_d3;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void set_expected_digits(input int t, input bit ovf);
        if (ovf) begin
            e_d0 = 8'h40; e_d1 = 8'hC0; e_d2 = 8'h40; e_d3 = 8'h40;
        end else begin
            e_d0 = seg_tab[t % 10];
            e_d1 = 8'h80 | seg_tab[(t / 10) % 10];
            e_d2 = seg_tab[(t / 100) % 10];
            e_d3 = seg_tab[(t / 1000) % 10];
`ifdef LEADING_ZERO_BLANK_EN
            if (t < 1000) e_d3 = 8'h00;
            if (t < 100)  e_d2 = 8'h00;
`endif
        end
    endfunction

    // advance the model across one rising edge with the inputs the DUT sampled
    task automatic model_edge(input bit rst, input bit r_ss, input bit r_clr);
        bit raw_now [2];
        bit press   [2];
        bit synced;
        bit tick;
        bit new_run;
        raw_now[0] = r_ss;
        raw_now[1] = r_clr;
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                m_pipe[b][0] = 1'b0; m_pipe[b][1] = 1'b0;
                m_hist[b] = '0; m_level[b] = 1'b0;
            end
            m_tenths = 0; m_phase = 0; m_run = 1'b0; m_ovf = 1'b0;
            set_expected_digits(0, 1'b0);
            return;
        end
        set_expected_digits(m_tenths, m_ovf);
        for (int b = 0; b < 2; b++) begin
            synced = m_pipe[b][1];
            m_pipe[b][1] = m_pipe[b][0];
            m_pipe[b][0] = raw_now[b];
            m_hist[b] = {m_hist[b][DEB-2:0], synced};
            press[b] = 1'b0;
            if (m_level[b] ? (m_hist[b] == '0) : (m_hist[b] == '1)) begin
                m_level[b] = ~m_level[b];
                press[b]   = m_level[b];
            end
        end
        tick = m_run && (m_phase == TICK_DIV - 1);
        if (press[1]) begin
            m_tenths = 0; m_phase = 0; m_run = 1'b0; m_ovf = 1'b0;
        end else begin
            new_run = m_run;
            if (press[0] && !m_ovf) new_run = !m_run;
            if (tick) begin
                m_phase = 0;
                if (m_tenths == 9999) begin
                    m_ovf = 1'b1;
                    new_run = 1'b0;
                end else begin
                    m_tenths++;
                end
            end else if (m_run) begin
                m_phase++;
            end
            m_run = new_run;
        end
    endtask

    task automatic cycle(input bit rst, input bit ss, input bit clr);
        @(negedge clock);
        reset = rst;
        button_start_stop = ss;
        button_clear = clr;
        @(posedge clock);
        model_edge(rst, ss, clr);
        #1;
        check_val("running",  {7'd0, running},  {7'd0, m_run});
        check_val("overflow", {7'd0, overflow}, {7'd0, m_ovf});
        check_val("digit0", digit0, e_d0);
        check_val("digit1", digit1, e_d1);
        check_val("digit2", digit2, e_d2);
        check_val("digit3", digit3, e_d3);
    endtask

    // which: 0 start/stop, 1 clear, 2 both
    task automatic drive_btn(input int which, input bit v);
        cycle(1'b0, (which != 1) && v, (which != 0) && v);
    endtask

    task automatic press_btn(input int which, input int hold, input int bounces);
        for (int i = 0; i < bounces; i++) drive_btn(which, 1'($urandom_range(0, 1)));
        for (int i = 0; i < hold; i++)    drive_btn(which, 1'b1);
        for (int i = 0; i < bounces; i++) drive_btn(which, 1'($urandom_range(0, 1)));
        for (int i = 0; i < DEB + 3; i++) drive_btn(which, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int op;
        // reset for two cycles, then fixed reset values
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        check_val("rst_digit1_const", digit1, 8'hBF);
        check_val("rst_digit0_const", digit0, 8'h3F);

        // bounce rejection: 1,0,1,0 then held, then release
        drive_btn(0, 1'b1); drive_btn(0, 1'b0);
        drive_btn(0, 1'b1); drive_btn(0, 1'b0);
        for (int i = 0; i < 10; i++) drive_btn(0, 1'b1);
        check_val("bounce_running_const", {7'd0, running}, 8'd1);
        idle(10);

        // count a while, stop, resume, clear
        idle(44);
        press_btn(0, 5, 0);
        idle(20);
        press_btn(0, 5, 0);
        idle(13);
        press_btn(1, 5, 2);

        // random button activity with occasional mid-run resets
        for (int it = 0; it < 300; it++) begin
            op = int'($urandom_range(0, 11));
            case (op)
                0, 1, 2, 3, 4: press_btn(0, int'($urandom_range(1, 8)), int'($urandom_range(0, 4)));
                5:             press_btn(1, int'($urandom_range(1, 8)), int'($urandom_range(0, 4)));
                6:             press_btn(2, int'($urandom_range(3, 8)), 0);
                7: begin
                    for (int i = 0; i < int'($urandom_range(1, 2)); i++)
                        cycle(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                end
                default:       idle(int'($urandom_range(0, 40)));
            endcase
        end

        // run to saturation past 999.9
        press_btn(1, 5, 0);
        press_btn(0, 5, 0);
        idle(40050);
        check_val("ovf_flag_const",   {7'd0, overflow}, 8'd1);
        check_val("ovf_running_const", {7'd0, running}, 8'd0);
        check_val("ovf_digit1_const", digit1, 8'hC0);
        check_val("ovf_digit0_const", digit0, 8'h40);
        press_btn(0, 5, 1);
        check_val("ovf_ignore_const", {7'd0, running}, 8'd0);
        press_btn(1, 5, 0);
        idle(2);
        check_val("clr_ovf_const", {7'd0, overflow}, 8'd0);
        check_val("clr_digit1_const", digit1, 8'hBF);

        // simultaneous start/stop and clear while running
        press_btn(0, 5, 0);
        idle(22);
        press_btn(2, 6, 0);
        idle(4);
        check_val("simul_running_const", {7'd0, running}, 8'd0);
        check_val("simul_digit0_const", digit0, 8'h3F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/stopwatch_digit_source.md
Name: stopwatch_digit_source

Overview:
Upstream feeder for the 4-digit multiplexed 7-segment driver. Debounces two raw push-buttons and runs a 0.1 s-resolution BCD stopwatch (000.0–999.9 s). Presents four registered 8-bit segment patterns (digit0..digit3) in the driver's segment encoding, so the driver only has to scan them.

Parameters:
TICK_DIV, 2_400_000, clock cycles per 0.1 s tick (24 MHz clock); must be >= 2
DEBOUNCE_CYCLES, 240_000, consecutive stable cycles (10 ms) required before a debounced level changes; must be >= 1

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
button_start_stop  input  1  raw asynchronous button, active-high when pressed
button_clear  input  1  raw asynchronous button, active-high when pressed
digit0  output  8  segment pattern, tenths of seconds (rightmost)
digit1  output  8  segment pattern, units of seconds; DP (bit 7) always lit
digit2  output  8  segment pattern, tens of seconds
digit3  output  8  segment pattern, hundreds of seconds (leftmost)
running  output  1  1 while counting
overflow  output  1  1 after count saturated past 999.9

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset). Every register is cleared only on a rising clock edge with reset=1.
- Segment encoding is active-high: bit7 DP, bit6 middle, bit5 right-low, bit4 bottom, bit3 left-low, bit2 left-high, bit1 top, bit0 right-high.
- Digit codes: 0=0011_1111, 1=0010_0001, 2=0101_1011, 3=0111_0011, 4=0110_0101, 5=0111_0110, 6=0111_1110, 7=0010_0011, 8=0111_1111, 9=0111_0111, dash=0100_0000.
- Reset values: running=0; overflow=0; BCD=0000; prescaler=0; debounced levels=0; digit0/2/3=0011_1111; digit1=1011_1111.
- Input path: each button passes through a 2-flop synchronizer and then a debouncer with a counter.
  - While the synced value differs from the debounced level, the counter increments; any return to equality resets the counter to 0.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the synced value and the counter clears.
  - A debounced 0->1 transition produces a one-cycle press pulse. Release produces no pulse.
- Control, evaluated each cycle:
  - Clear pulse: BCD=0, prescaler=0, overflow=0, running=0. Clear takes priority over a start/stop pulse in the same cycle.
  - Start/stop pulse with no clear: if overflow=1, ignored. Otherwise running toggles.
  - Stopping holds the prescaler value, so a partial tick resumes on restart.
- Prescaler: advances only while running=1. When it equals TICK_DIV-1 the cycle is a tick and the prescaler wraps to 0.
- On a tick, the BCD counter increments with decimal carry (digit 9 -> 0 and carry to the next digit).
  - Tick at 999.9: BCD holds 999.9, running=0, overflow=1, all on the same edge.
- Outputs are registered one cycle after the BCD state (BCD update at edge N, digitX at edge N+1).
  - With overflow=1, all four digits show dash (digit1 = 1100_0000, DP kept). Otherwise each digit shows its BCD code, with DP added on digit1.
- running and overflow are direct register outputs with no extra latency.
- A reset asserted mid-count or mid-debounce returns every register to its reset value in that cycle. A button held through reset is re-debounced afterwards and produces a pulse once stable.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: digit3, and then digit2, output 0000_0000 while they and every more-significant digit are zero. digit1 and digit0 are never blanked. Example: 7.3 s shows blank, blank, "7.", "3". Overflow dashes are never blanked.
- Undefined: all digits are always shown, including leading zeros ("007.3").

Test Plan:
Use TICK_DIV=4 and DEBOUNCE_CYCLES=3 unless noted.
- Reset: hold reset 2 cycles -> digit3..0 = 0011_1111, 0011_1111, 1011_1111, 0011_1111; running=0; overflow=0.
- Bounce rejection: start_stop toggles 1,0,1,0 each cycle, then stays 1 -> exactly one pulse after 2 sync + 3 stable cycles, running=1; no second pulse on release.
- Count: start, let 11 ticks elapse (44 running cycles) -> digit1=1010_0001 ("1."), digit0=0010_0001 ("1"), digit2=digit3=0011_1111.
- Stop/resume: stop 2 cycles into a tick period, wait 20 cycles, restart -> next tick occurs 2 running cycles later; BCD unchanged while stopped.
- Overflow: preload via run to 999.9, one more tick -> running=0, overflow=1, digits 0100_0000/0100_0000/1100_0000/0100_0000; start_stop press is ignored; clear -> all zeros, overflow=0.
- Simultaneous: start_stop and clear debounced pulses land in the same cycle while running -> running=0, BCD=0000.
